// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: opcode classes, error codes and sequencer states.
package cpu_pkg;

  // Opcode classes, decoded from opcode[7:4]; HALT is a full 8-bit match.
  localparam logic [3:0] OPC_BR   = 4'hA;
  localparam logic [3:0] OPC_JMP  = 4'hB;
  localparam logic [3:0] OPC_CALL = 4'hC;
  localparam logic [3:0] OPC_RET  = 4'hD;
  localparam logic [7:0] OPC_HALT = 8'hFF;

  // Sticky error codes reported by the sequencer.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The caller decides what to do on overflow/underflow;
// push when full and pop when empty are simply ignored here.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);

  logic [SP_W-1:0]  sp_reg;
  logic [W-1:0]     mem_reg [DEPTH];
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;

  assign full     = (sp_reg == DEPTH_SP);
  assign empty    = (sp_reg == '0);
  assign push_idx = sp_reg[IDX_W-1:0];
  assign top_idx  = IDX_W'(sp_reg - SP_W'(1));
  // Top of stack is read combinationally so a return redirects in one cycle.
  assign dout     = mem_reg[top_idx];

  // Stack pointer: one step up on push, one step down on pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + SP_W'(1);
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - SP_W'(1);
    end
  end

  // Entry storage; reset wipes contents so no stale return address survives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push && !full) begin
      mem_reg[push_idx] <= din;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: picks the next PC from opcode class, target and
// the condition flag, keeps a return stack, and flushes fetch after redirects.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              RET_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [7:0]      opcode,
  input  logic [PC_W-1:0] target,
  input  logic            cond_i,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            halted,
  output logic [1:0]      err
);

  seq_state_t      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            halted_reg, halted_next;
  logic [1:0]      err_reg, err_next;

  logic            accept;
  logic [PC_W-1:0] pc_inc;
  logic            stk_push, stk_pop;
  logic [PC_W-1:0] stk_top;
  logic            stk_full, stk_empty;

  assign accept = en && instr_valid && (state_reg == RUN);
  assign pc_inc = pc_reg + PC_W'(1);

  ret_stack #(
    .DEPTH (RET_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-state decode: redirects go through FLUSH, stack faults latch HALT.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    halted_next = halted_reg;
    err_next    = err_reg;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    case (state_reg)
      RUN: begin
        if (accept) begin
          if (opcode == OPC_HALT) begin
            halted_next = 1'b1;
            state_next  = HALT;
          end else begin
            case (opcode[7:4])
              OPC_BR: begin
                if (cond_i) begin
                  pc_next    = target;
                  state_next = FLUSH;
                end else begin
                  pc_next = pc_inc;
                end
              end
              OPC_JMP: begin
                pc_next    = target;
                state_next = FLUSH;
              end
              OPC_CALL: begin
                if (stk_full) begin
                  err_next    = ERR_OVF;
                  halted_next = 1'b1;
                  state_next  = HALT;
                end else begin
                  stk_push   = 1'b1;
                  pc_next    = target;
                  state_next = FLUSH;
                end
              end
              OPC_RET: begin
                if (stk_empty) begin
                  err_next    = ERR_UNF;
                  halted_next = 1'b1;
                  state_next  = HALT;
                end else begin
                  stk_pop    = 1'b1;
                  pc_next    = stk_top;
                  state_next = FLUSH;
                end
              end
              default: pc_next = pc_inc;
            endcase
          end
        end
      end
      FLUSH: begin
        if (en) begin
          state_next = RUN;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = RUN;
    endcase
  end

  // State registers; reset overrides enable and any in-progress flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      halted_reg <= 1'b0;
      err_reg    <= ERR_NONE;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      halted_reg <= halted_next;
      err_reg    <= err_next;
    end
  end

  assign pc          = pc_reg;
  assign flush       = (state_reg == FLUSH);
  assign instr_ready = (state_reg == RUN);
  assign halted      = halted_reg;
  assign err         = err_reg;

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Program-counter sequencer that consumes the 1-bit condition flag from the condition-evaluation unit.
- Applies the flag, together with the current instruction's opcode and target, to select the next PC: sequential, conditional branch, jump, call or return.
- Holds a small return-address stack and drives a one-cycle fetch flush after every taken redirect.
- Sits between the instruction fetch stage and the condition unit in the 8-bit CPU core.

Parameters:
- PC_W, 8, program counter and target width.
- RET_DEPTH, 4, number of return-stack entries (power of two, minimum 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  global enable; when low, all state holds (stall).
- instr_valid  input  1  fetch presents a valid instruction.
- instr_ready  output  1  sequencer can accept an instruction; equals (state==RUN).
- opcode  input  8  instruction opcode; class is opcode[7:4].
- target  input  PC_W  branch, jump or call destination.
- cond_i  input  1  condition flag from the condition unit, valid in the same cycle as the instruction.
- pc  output  PC_W  current program counter (registered).
- flush  output  1  high for exactly one cycle after a taken redirect; fetch discards its in-flight word.
- halted  output  1  sticky halt indication.
- err  output  2  sticky error code: 00 none, 01 stack overflow, 10 stack underflow.

Behaviour:
- Reset (rst==0 at a clock edge), regardless of state or en:
  - pc=RESET_PC, flush=0, halted=0, err=00.
  - Stack pointer sp=0; state=RUN.
- Accept condition: en && instr_valid && instr_ready. With no accept, pc, sp and stack hold. flush still follows state (see FLUSH).
- Opcode classes on accept in RUN; pc+1 wraps modulo 2^PC_W (0xFF -> 0x00):
  - 0xFF (HALT): pc holds, halted<=1, state->HALT. Checked before class decode.
  - Class 0xA (conditional branch):
    - cond_i==1: pc<=target, state->FLUSH.
    - cond_i==0: pc<=pc+1, stay in RUN.
  - Class 0xB (jump): pc<=target, state->FLUSH; cond_i is ignored.
  - Class 0xC (call):
    - sp==RET_DEPTH: err<=01, halted<=1, state->HALT, pc holds.
    - Otherwise: stack[sp]<=pc+1, sp<=sp+1, pc<=target, state->FLUSH.
  - Class 0xD (return):
    - sp==0: err<=10, halted<=1, state->HALT, pc holds.
    - Otherwise: pc<=stack[sp-1], sp<=sp-1, state->FLUSH.
  - Any other class: pc<=pc+1.
- FLUSH state:
  - Lasts one enabled cycle; flush==1 while state==FLUSH, otherwise 0.
  - instr_ready=0, so the presented instruction is not consumed.
  - Next enabled edge goes to RUN. If en is low, FLUSH (and flush=1) is held until en returns.
- HALT state: instr_ready=0 and nothing changes until reset; err and halted are sticky.
- Latency: the redirected pc is visible on the cycle after accept; the earliest next accept is two cycles after a taken redirect.
- Stack: a full stack still accepts returns; an empty stack still accepts calls. Pushed values are wrapped pc+1.
- A reset mid-FLUSH or mid-stall takes priority and clears everything, including stack contents (sp=0).

Decomposition:
- Shared package (cpu_pkg) holds:
  - Opcode class constants: OPC_BR=4'hA, OPC_JMP=4'hB, OPC_CALL=4'hC, OPC_RET=4'hD, OPC_HALT=8'hFF.
  - Error code constants ERR_NONE, ERR_OVF, ERR_UNF.
  - State encoding RUN, FLUSH, HALT.
- One sub-module, ret_stack: a RET_DEPTH-entry LIFO with push, pop, full and empty flags and a synchronous active-low reset. The top-level FSM owns the overflow/underflow decision.

Test Plan:
- Sequential wrap: RESET_PC=0xFE, two accepts of opcode 0x10 -> pc 0xFE, 0xFF, 0x00; flush stays 0.
- Conditional branch: pc=0x05, opcode 0xA2, target 0x40:
  - cond_i=1 -> next cycle pc=0x40, flush=1 for one cycle, instr_ready=0 that cycle.
  - cond_i=0 -> pc=0x06, no flush.
- Call/return: pc=0x10, opcode 0xC0 target 0x80 -> pc=0x80, sp=1. After the flush cycle, opcode 0xD0 -> pc=0x11, sp=0.
- Overflow: RET_DEPTH=4, five consecutive calls -> fifth call leaves pc unchanged, err=01, halted=1, instr_ready stays 0. A subsequent rst low for one cycle -> pc=RESET_PC, err=00, halted=0.
- Underflow and stall: opcode 0xD0 with sp=0 -> err=10, halted=1. Separately, en=0 during FLUSH -> flush held at 1 and pc unchanged until en returns.
